pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised fetch-address generator for the MIPS front end; successor to the simple PC register.
//  Holds the PC and drives instruction-memory chip enable. Supports a configurable reset vector,
//  an exception vector, ERET return, pipeline stall, and a fetch-grant handshake.
//  Branches that arrive during a stall are buffered in a pending-redirect register.
//  Sits between the ID/EX branch logic, the CP0 exception logic and the instruction ROM/cache port.
// PARAMETERS
//  ADDR_W      32            PC / target width in bits
//  RESET_VEC   32'h0000_0000 first fetch address after reset
//  EXC_VEC     32'h0000_0020 exception handler entry address
//  INST_BYTES  4             sequential increment; power of two, >=1
// PORTS
//  clk                      in   1       clock, rising edge
//  rst                      in   1       reset: asynchronous, active-high
//  stall_i                  in   1       pipeline stall; blocks sequential advance and branch apply
//  branch_flag_i            in   1       branch taken this cycle
//  branch_target_address_i  in   ADDR_W  branch target
//  exc_flag_i               in   1       exception taken; redirect to EXC_VEC
//  eret_flag_i              in   1       exception return; redirect to epc_i
//  epc_i                    in   ADDR_W  return address from CP0
//  if_gnt_i                 in   1       instruction memory accepted the fetch at pc_o this cycle
//  pc_o                     out  ADDR_W  current fetch address
//  ce_o                     out  1       instruction memory chip enable
//  redirect_pend_o          out  1       a buffered branch is waiting for the stall to clear
//  addr_err_o               out  1       one-cycle pulse: misaligned redirect target accepted
// BEHAVIOUR
//  Reset (async, while rst=1): pc_o=RESET_VEC, ce_o=0, redirect_pend_o=0, addr_err_o=0, pend_addr=0, state=S_BOOT.
//  FSM states:
//   S_BOOT: first edge after rst falls sets ce_o<=1 and moves to S_RUN. pc_o stays RESET_VEC,
//           so the first fetch address is RESET_VEC. All inputs are ignored in S_BOOT.
//   S_RUN:  ce_o=1. The PC update each edge follows the priority list below.
//  S_RUN priority (highest first), evaluated each edge:
//   1 exc_flag_i: pc_o<=EXC_VEC. Clears pend. Applies even when stall_i=1.
//   2 eret_flag_i: pc_o<=epc_i. Clears pend. Applies even when stall_i=1.
//   3 branch_flag_i && !stall_i: pc_o<=target. Clears pend.
//   4 branch_flag_i && stall_i: pend_addr<=target; pend<=1; pc_o holds. A newer branch overwrites pend_addr.
//   5 pend && !stall_i: pc_o<=pend_addr; pend<=0.
//   6 !stall_i && if_gnt_i: pc_o<=pc_o+INST_BYTES, mod 2^ADDR_W (wraps from all-ones to 0, no flag).
//   7 otherwise: pc_o holds. An ungranted fetch stays at the same address.
//  Redirect latency: a redirect sampled on edge N appears on pc_o after edge N (1 cycle).
//   A redirect discards any ungranted fetch at the old PC.
//  Alignment:
//   Every redirect target (branch, epc, pend) is written with its low log2(INST_BYTES) bits forced to 0.
//   addr_err_o pulses high for exactly 1 cycle when a discarded low bit was nonzero.
//   A target buffered under stall is checked when it is applied, not when it is captured.
//  redirect_pend_o equals the internal pend bit (registered).
//  Simultaneous exc_flag_i and eret_flag_i: exception wins.
//  rst asserted mid-operation: immediate return to the reset values above, including loss of any pending branch.
// TESTING
//  T1 Release rst; if_gnt_i=1 constantly -> ce_o 0 for 1 cycle then 1; pc_o sequence 0,0,4,8,... (defaults).
//  T2 In S_RUN, hold if_gnt_i=0 for 3 cycles at pc=0x10 -> pc_o stays 0x10; on grant it steps to 0x14.
//  T3 stall_i=1, then branch to 0x100 for 1 cycle, stall held 2 more cycles ->
//     redirect_pend_o=1 and pc_o held; when stall drops, pc_o=0x100 next cycle and pend clears.
//  T4 Branch to 0x200 with exc_flag_i=1 in the same cycle -> pc_o=0x20.
//     Then eret_flag_i=1 with epc_i=0x203 -> pc_o=0x200 and addr_err_o pulses for 1 cycle.
//  T5 Force pc=32'hFFFF_FFFC with grant -> next pc_o=0. Assert rst mid-stall with pend set ->
//     pc_o=RESET_VEC, ce_o=0, pend=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-address generator for the MIPS front end.
//
// It holds the fetch PC and drives the instruction-memory chip enable. It supports
// a reset vector, an exception vector, ERET return, pipeline stall and a fetch-grant
// handshake. A branch that arrives during a stall is buffered until the stall clears.
//
// Ports
//   clk                      in   1       clock, rising edge
//   rst                      in   1       asynchronous, active-high reset
//   stall_i                  in   1       pipeline stall
//   branch_flag_i            in   1       branch taken this cycle
//   branch_target_address_i  in   ADDR_W  branch target
//   exc_flag_i               in   1       exception taken, redirect to EXC_VEC
//   eret_flag_i              in   1       exception return, redirect to epc_i
//   epc_i                    in   ADDR_W  return address from CP0
//   if_gnt_i                 in   1       memory accepted the fetch at pc_o
//   pc_o                     out  ADDR_W  current fetch address
//   ce_o                     out  1       instruction memory chip enable
//   redirect_pend_o          out  1       buffered branch waiting for the stall to clear
//   addr_err_o               out  1       one-cycle pulse: misaligned redirect target accepted
module pc_gen_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0]    EXC_VEC    = ADDR_W'(32'h0000_0020),
  parameter int unsigned          INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  input  logic              exc_flag_i,
  input  logic              eret_flag_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic              if_gnt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              redirect_pend_o,
  output logic              addr_err_o
);

  // Low bits that must be zero in an aligned fetch address (all-zero when INST_BYTES == 1).
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PcInc     = ADDR_W'(INST_BYTES);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_d;
  logic                r_pend;
  logic                w_pend_d;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic [ADDR_W-1:0]   w_pend_addr_d;
  logic                r_addr_err;
  logic                w_addr_err_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: boot lasts exactly one edge after reset release.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StBoot:  w_state_d = StRun;
      StRun:   w_state_d = StRun;
      default: w_state_d = StBoot;
    endcase
  end

  // Outputs decoded from the registered state and datapath registers.
  always_comb begin
    ce_o            = (r_state == StRun);
    pc_o            = r_pc;
    redirect_pend_o = r_pend;
    addr_err_o      = r_addr_err;
  end

  // PC update, in priority order. Redirect targets are forced aligned; a nonzero
  // discarded low bit raises a one-cycle error. Buffered targets are checked on apply.
  always_comb begin
    w_pc_d        = r_pc;
    w_pend_d      = r_pend;
    w_pend_addr_d = r_pend_addr;
    w_addr_err_d  = 1'b0;
    if (r_state == StRun) begin
      if (exc_flag_i) begin
        w_pc_d   = EXC_VEC;
        w_pend_d = 1'b0;
      end else if (eret_flag_i) begin
        w_pc_d       = epc_i & ~AlignMask;
        w_addr_err_d = |(epc_i & AlignMask);
        w_pend_d     = 1'b0;
      end else if (branch_flag_i && !stall_i) begin
        w_pc_d       = branch_target_address_i & ~AlignMask;
        w_addr_err_d = |(branch_target_address_i & AlignMask);
        w_pend_d     = 1'b0;
      end else if (branch_flag_i && stall_i) begin
        // Newest branch under stall wins; the alignment check waits until it is applied.
        w_pend_addr_d = branch_target_address_i;
        w_pend_d      = 1'b1;
      end else if (r_pend && !stall_i) begin
        w_pc_d       = r_pend_addr & ~AlignMask;
        w_addr_err_d = |(r_pend_addr & AlignMask);
        w_pend_d     = 1'b0;
      end else if (!stall_i && if_gnt_i) begin
        // Wraps modulo 2^ADDR_W.
        w_pc_d = r_pc + PcInc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_VEC;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_pc        <= w_pc_d;
      r_pend      <= w_pend_d;
      r_pend_addr <= w_pend_addr_d;
      r_addr_err  <= w_addr_err_d;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        exc_flag_i;
  logic        eret_flag_i;
  logic [31:0] epc_i;
  logic        if_gnt_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        redirect_pend_o;
  logic        addr_err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        err;
  } exp_t;

  exp_t sb[$];

  pc_gen_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .exc_flag_i              (exc_flag_i),
    .eret_flag_i             (eret_flag_i),
    .epc_i                   (epc_i),
    .if_gnt_i                (if_gnt_i),
    .pc_o                    (pc_o),
    .ce_o                    (ce_o),
    .redirect_pend_o         (redirect_pend_o),
    .addr_err_o              (addr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] pc, input logic ce,
                      input logic pend, input logic err);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.ce   = ce;
    e.pend = pend;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the current DUT outputs.
  task automatic compare_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (pc_o === e.pc) else begin
        failures++;
        $error("FAIL %s pc_o observed=%h expected=%h", e.tag, pc_o, e.pc);
      end
      checks++;
      assert (ce_o === e.ce) else begin
        failures++;
        $error("FAIL %s ce_o observed=%b expected=%b", e.tag, ce_o, e.ce);
      end
      checks++;
      assert (redirect_pend_o === e.pend) else begin
        failures++;
        $error("FAIL %s redirect_pend_o observed=%b expected=%b", e.tag, redirect_pend_o, e.pend);
      end
      checks++;
      assert (addr_err_o === e.err) else begin
        failures++;
        $error("FAIL %s addr_err_o observed=%b expected=%b", e.tag, addr_err_o, e.err);
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then check after the edge.
  task automatic step(input string tag, input logic stall, input logic br,
                      input logic [31:0] tgt, input logic exc, input logic eret,
                      input logic [31:0] epc, input logic gnt,
                      input logic [31:0] exp_pc, input logic exp_ce,
                      input logic exp_pend, input logic exp_err);
    stall_i                 = stall;
    branch_flag_i           = br;
    branch_target_address_i = tgt;
    exc_flag_i              = exc;
    eret_flag_i             = eret;
    epc_i                   = epc;
    if_gnt_i                = gnt;
    push(tag, exp_pc, exp_ce, exp_pend, exp_err);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    rst                     = 1'b1;
    stall_i                 = 1'b0;
    branch_flag_i           = 1'b0;
    branch_target_address_i = '0;
    exc_flag_i              = 1'b0;
    eret_flag_i             = 1'b0;
    epc_i                   = '0;
    if_gnt_i                = 1'b1;

    #1;
    push("reset_values", 32'h0, 1'b0, 1'b0, 1'b0);
    compare_out();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: boot edge keeps pc at the reset vector, then sequential fetch.
    //         tag          stl br tgt          exc ert epc          gnt  pc            ce pnd err
    step("boot",          0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        1, 0, 0);
    step("seq_4",         0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h4,        1, 0, 0);
    step("seq_8",         0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h8,        1, 0, 0);
    step("seq_c",         0, 0, 32'h0,       0, 0, 32'h0,       1, 32'hC,        1, 0, 0);
    step("seq_10",        0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h10,       1, 0, 0);

    // T2: ungranted fetch holds.
    for (int i = 0; i < 3; i++)
      step("nogrant_hold", 0, 0, 32'h0,      0, 0, 32'h0,       0, 32'h10,       1, 0, 0);
    step("grant_14",      0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       1, 0, 0);

    // T3: branch under stall is buffered, applied once the stall drops.
    step("stall_hold",    1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       1, 0, 0);
    step("stall_branch",  1, 1, 32'h100,     0, 0, 32'h0,       1, 32'h14,       1, 1, 0);
    step("stall_pend1",   1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       1, 1, 0);
    step("stall_pend2",   1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h14,       1, 1, 0);
    step("pend_apply",    0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h100,      1, 0, 0);

    // T4: exception beats branch; misaligned ERET target is aligned and flagged once.
    step("exc_over_br",   0, 1, 32'h200,     1, 0, 32'h0,       1, 32'h20,       1, 0, 0);
    step("eret_misalign", 0, 0, 32'h0,       0, 1, 32'h203,     1, 32'h200,      1, 0, 1);
    step("err_one_cycle", 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h200,      1, 0, 0);
    step("exc_over_eret", 0, 0, 32'h0,       1, 1, 32'h80,      1, 32'h20,       1, 0, 0);
    step("eret_in_stall", 1, 0, 32'h0,       0, 1, 32'h40,      1, 32'h40,       1, 0, 0);

    // Buffered misaligned target: no error at capture, error when applied.
    step("cap_misalign",  1, 1, 32'h301,     0, 0, 32'h0,       1, 32'h40,       1, 1, 0);
    step("apply_misalign",0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h300,      1, 0, 1);
    // Newer branch under stall overwrites the buffered target.
    step("cap_400",       1, 1, 32'h400,     0, 0, 32'h0,       0, 32'h300,      1, 1, 0);
    step("cap_500",       1, 1, 32'h500,     0, 0, 32'h0,       0, 32'h300,      1, 1, 0);
    step("apply_500",     0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h500,      1, 0, 0);
    // Exception under stall clears a pending branch.
    step("cap_600",       1, 1, 32'h600,     0, 0, 32'h0,       1, 32'h500,      1, 1, 0);
    step("exc_clr_pend",  1, 0, 32'h0,       1, 0, 32'h0,       1, 32'h20,       1, 0, 0);
    step("no_stale_pend", 0, 0, 32'h0,       0, 0, 32'h0,       0, 32'h20,       1, 0, 0);

    // T5: wrap from the top of the address space, then reset mid-stall with pend set.
    step("br_top",        0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,     0, 32'hFFFF_FFFC, 1, 0, 0);
    step("wrap_0",        0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        1, 0, 0);
    step("cap_700",       1, 1, 32'h700,     0, 0, 32'h0,       1, 32'h0,        1, 1, 0);
    step("branch_8",      1, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        1, 1, 0);

    // Async reset between edges: outputs must change before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    push("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    compare_out();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    stall_i = 1'b0;
    step("reboot",        0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h0,        1, 0, 0);
    step("reboot_seq",    0, 0, 32'h0,       0, 0, 32'h0,       1, 32'h4,        1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
